// File: rtl/lzc_pkg.sv
// Shared types and constants for the leading-zero-count scheduler.
package lzc_pkg;

    localparam int ZEROS_W = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_FEED,
        S_WAIT,
        S_RESP
    } state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/lzc_sched_arb.sv
// Two-way round-robin arbiter: a lone requester always wins, a tie goes to
// whoever was not served last.
module rr_arb2
    import lzc_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic accept,
    output logic grant
);

    req_id_t last_served;

    // Grant selection from current requests and the last-served pointer
    always_comb begin
        if (req0 && !req1) begin
            grant = 1'b0;
        end else if (req1 && !req0) begin
            grant = 1'b1;
        end else begin
            grant = ~last_served;
        end
    end

    // Remember who was served; reset favours requester 0 next
    always_ff @(posedge clk) begin
        if (rst) begin
            last_served <= 1'b1;
        end else if (accept) begin
            last_served <= grant;
        end
    end

endmodule

// File: rtl/lzc_sched.sv
// Serialises one operand at a time from two requesters into a word-wide
// leading-zero counter and returns the count (or a timeout) to the owner.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | ready to accept an operand from the granted requester
// S_SETUP | mode driven to the LZC one cycle ahead of the first word
// S_FEED  | WORD data words sent, most-significant first
// S_WAIT  | waiting for the LZC result, bounded by TIMEOUT cycles
// S_RESP  | one-cycle response pulse, then back to idle
module lzc_sched
    import lzc_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int WORD    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [WIDTH*WORD-1:0]  req0_data,
    input  logic                   req0_mode,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [WIDTH*WORD-1:0]  req1_data,
    input  logic                   req1_mode,
    output logic                   rsp_valid,
    output logic                   rsp_id,
    output logic [ZEROS_W-1:0]     rsp_zeros,
    output logic                   rsp_err,
    output logic                   lzc_ivalid,
    output logic [WIDTH-1:0]       lzc_data,
    output logic                   lzc_mode,
    input  logic                   lzc_ovalid,
    input  logic [ZEROS_W-1:0]     lzc_zeros
);

    localparam int OP_W  = WIDTH * WORD;
    localparam int IDX_W = $clog2(WORD + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_t            state;
    logic [OP_W-1:0]   op_q;
    logic [IDX_W-1:0]  idx;
    logic [TMO_W-1:0]  tmo;
    req_id_t           id_q;
    logic              grant;
    logic              idle;
    logic              accept;

    // Ready only in idle, only for the granted requester, never during reset
    assign idle       = (state == S_IDLE) && !rst;
    assign req0_ready = idle && req0_valid && (grant == 1'b0);
    assign req1_ready = idle && req1_valid && (grant == 1'b1);
    assign accept     = req0_ready || req1_ready;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req0   (req0_valid),
        .req1   (req1_valid),
        .accept (accept),
        .grant  (grant)
    );

    // Sequencing FSM with registered LZC and response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            op_q       <= '0;
            idx        <= '0;
            tmo        <= '0;
            id_q       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_zeros  <= '0;
            rsp_err    <= 1'b0;
            lzc_ivalid <= 1'b0;
            lzc_data   <= '0;
            lzc_mode   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q     <= grant ? req1_data : req0_data;
                        lzc_mode <= grant ? req1_mode : req0_mode;
                        id_q     <= grant;
                        state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    lzc_ivalid <= 1'b1;
                    lzc_data   <= op_q[OP_W-1 -: WIDTH];
                    op_q       <= op_q << WIDTH;
                    idx        <= IDX_W'(1);
                    state      <= S_FEED;
                end
                S_FEED: begin
                    if (idx == IDX_W'(WORD)) begin
                        lzc_ivalid <= 1'b0;
                        lzc_data   <= '0;
                        tmo        <= '0;
                        state      <= S_WAIT;
                    end else begin
                        lzc_data <= op_q[OP_W-1 -: WIDTH];
                        op_q     <= op_q << WIDTH;
                        idx      <= idx + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (lzc_ovalid) begin
                        rsp_zeros <= lzc_zeros;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_id    <= id_q;
                        state     <= S_RESP;
                    end else if (tmo == TMO_W'(TIMEOUT - 1)) begin
                        rsp_zeros <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_id    <= id_q;
                        state     <= S_RESP;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lzc_sched.sv
// Directed bench for lzc_sched at WIDTH=8, WORD=4, TIMEOUT=64.
module tb_lzc_sched;
    import lzc_pkg::*;

    logic        clk;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_data, req1_data;
    logic        req0_mode, req1_mode;
    logic        rsp_valid, rsp_id, rsp_err;
    logic [5:0]  rsp_zeros;
    logic        lzc_ivalid, lzc_mode, lzc_ovalid;
    logic [7:0]  lzc_data;
    logic [5:0]  lzc_zeros;

    int n_total = 0;
    int n_pass  = 0;

    lzc_sched #(.WIDTH(8), .WORD(4), .TIMEOUT(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_mode  (req0_mode),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_mode  (req1_mode),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_zeros  (rsp_zeros),
        .rsp_err    (rsp_err),
        .lzc_ivalid (lzc_ivalid),
        .lzc_data   (lzc_data),
        .lzc_mode   (lzc_mode),
        .lzc_ovalid (lzc_ovalid),
        .lzc_zeros  (lzc_zeros)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Entered in an idle cycle with the requester inputs already driven.
    // spur_at: FEED index carrying a bogus OVALID (ZEROS=5), -1 for none.
    // ov_at:   WAIT cycle index carrying OVALID with ovz, -1 for timeout.
    task automatic serve(input logic eid, input logic [31:0] edata, input logic emode,
                         input int spur_at, input int ov_at, input logic [5:0] ovz,
                         input logic drop);
        #1;
        chk("idle_ready0", req0_ready, eid == 1'b0);
        chk("idle_ready1", req1_ready, eid == 1'b1);
        tick();
        if (drop) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            req0_data  = 32'hFFFF_FFFF;
            req1_data  = 32'hFFFF_FFFF;
            req0_mode  = ~req0_mode;
            req1_mode  = ~req1_mode;
        end
        #1;
        chk("setup_ready0", req0_ready, 0);
        chk("setup_ready1", req1_ready, 0);
        chk("setup_ivalid", lzc_ivalid, 0);
        chk("setup_mode", lzc_mode, emode);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == spur_at) begin
                lzc_ovalid = 1'b1;
                lzc_zeros  = 6'd5;
            end else begin
                lzc_ovalid = 1'b0;
            end
            chk("feed_ivalid", lzc_ivalid, 1);
            chk("feed_data", lzc_data, edata[31-8*i -: 8]);
            chk("feed_mode", lzc_mode, emode);
            chk("feed_rsp", rsp_valid, 0);
        end
        tick();
        lzc_ovalid = 1'b0;
        chk("wait_ivalid", lzc_ivalid, 0);
        chk("wait_data", lzc_data, 0);
        chk("wait_rsp", rsp_valid, 0);
        for (int w = 0; w < 64; w++) begin
            if (w == ov_at) begin
                lzc_ovalid = 1'b1;
                lzc_zeros  = ovz;
            end
            tick();
            lzc_ovalid = 1'b0;
            lzc_zeros  = 6'd0;
            if (w == ov_at || w == 63) break;
            chk("wait_no_rsp", rsp_valid, 0);
        end
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_id", rsp_id, eid);
        chk("rsp_err", rsp_err, ov_at < 0);
        chk("rsp_zeros", rsp_zeros, (ov_at < 0) ? 6'd0 : ovz);
        tick();
        chk("rsp_pulse_end", rsp_valid, 0);
        chk("rsp_zeros_hold", rsp_zeros, (ov_at < 0) ? 6'd0 : ovz);
        chk("rsp_err_hold", rsp_err, ov_at < 0);
    endtask

    initial begin
        rst        = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data  = '0;
        req1_data  = '0;
        req0_mode  = 1'b0;
        req1_mode  = 1'b0;
        lzc_ovalid = 1'b0;
        lzc_zeros  = '0;

        // Reset state
        repeat (3) tick();
        chk("reset_outs", {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_zeros, rsp_err,
                           lzc_ivalid, lzc_data, lzc_mode}, 0);
        chk("reset_state", dut.state, S_IDLE);
        rst = 1'b0;
        tick();

        // Single request from requester 0
        req0_valid = 1'b1;
        req0_data  = 32'h0000_0FFF;
        req0_mode  = 1'b0;
        serve(1'b0, 32'h0000_0FFF, 1'b0, -1, 2, 6'd20, 1'b1);

        // Contention from reset: grants alternate 0,1,0,1
        rst = 1'b1;
        tick();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data  = 32'h1234_5678;
        req0_mode  = 1'b0;
        req1_data  = 32'h0080_0001;
        req1_mode  = 1'b1;
        rst = 1'b0;
        serve(1'b0, 32'h1234_5678, 1'b0, -1, 0, 6'd3,  1'b0);
        serve(1'b1, 32'h0080_0001, 1'b1, -1, 4, 6'd17, 1'b0);
        serve(1'b0, 32'h1234_5678, 1'b0, -1, 1, 6'd11, 1'b0);
        serve(1'b1, 32'h0080_0001, 1'b1, -1, 0, 6'd25, 1'b1);

        // Reset during the second FEED cycle aborts the operation
        req0_valid = 1'b1;
        req0_data  = 32'hAABB_CCDD;
        req0_mode  = 1'b1;
        #1;
        chk("abort_ready0", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        tick();
        tick();
        chk("abort_feed2_data", lzc_data, 8'hBB);
        rst = 1'b1;
        tick();
        chk("abort_outs", {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_zeros, rsp_err,
                           lzc_ivalid, lzc_data, lzc_mode}, 0);
        chk("abort_state", dut.state, S_IDLE);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_no_rsp", rsp_valid, 0);
            chk("abort_stay_idle", dut.state, S_IDLE);
        end

        // Pointer after reset favours requester 0 on a tie
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("ptr_reset_ready0", req0_ready, 1);
        chk("ptr_reset_ready1", req1_ready, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

        // Timeout, lone requester 1 wins despite last served being 1
        req1_valid = 1'b1;
        req1_data  = 32'h0000_00F0;
        req1_mode  = 1'b0;
        serve(1'b1, 32'h0000_00F0, 1'b0, -1, -1, 6'd0, 1'b1);

        // Normal service after a timeout
        req0_valid = 1'b1;
        req0_data  = 32'h0100_0000;
        req0_mode  = 1'b0;
        serve(1'b0, 32'h0100_0000, 1'b0, -1, 0, 6'd7, 1'b1);

        // Spurious OVALID in FEED is ignored; real result in WAIT is reported
        req1_valid = 1'b1;
        req1_data  = 32'h00FF_0000;
        req1_mode  = 1'b0;
        serve(1'b1, 32'h00FF_0000, 1'b0, 1, 1, 6'd9, 1'b1);

        // All-zero operand, mode 1, count of 32 passes through
        req0_valid = 1'b1;
        req0_data  = 32'h0000_0000;
        req0_mode  = 1'b1;
        serve(1'b0, 32'h0000_0000, 1'b1, -1, 1, 6'd32, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lzc_sched.md
LZC_SCHED -- requirements
Module: lzc_sched

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the LZC input word width in bits.
REQ-002 The block SHALL have parameter WORD, default 4, the number of words per operand; valid range 2..16.
REQ-003 The block SHALL have parameter TIMEOUT, default 64, the maximum number of WAIT cycles for LZC_OVALID.
REQ-004 CLK  in  1  single clock; all logic on its rising edge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 REQ0_VALID / REQ1_VALID  in  1 each  requester n offers an operand.
REQ-007 REQ0_READY / REQ1_READY  out  1 each  requester n's operand accepted this cycle.
REQ-008 REQ0_DATA / REQ1_DATA  in  WIDTH*WORD each  operand; most-significant word at the top.
REQ-009 REQ0_MODE / REQ1_MODE  in  1 each  LZC mode for that operand.
REQ-010 RSP_VALID  out  1  one-cycle result pulse.
REQ-011 RSP_ID  out  1  requester the result belongs to.
REQ-012 RSP_ZEROS  out  6  leading-zero count.
REQ-013 RSP_ERR  out  1  timeout flag.
REQ-014 LZC_IVALID  out  1  word valid to the LZC.
REQ-015 LZC_DATA  out  WIDTH  word to the LZC.
REQ-016 LZC_MODE  out  1  mode to the LZC.
REQ-017 LZC_OVALID  in  1  LZC result valid.
REQ-018 LZC_ZEROS  in  6  LZC result.

Function
REQ-019 The FSM SHALL have the states IDLE, SETUP, FEED, WAIT and RESP; exactly one operand SHALL be in flight at a time.
REQ-020 In IDLE, REQn_READY SHALL be asserted combinationally only for the granted requester, and only while its REQn_VALID is high; both READY signals SHALL be low in all other states.
REQ-021 Arbitration SHALL be two-way round-robin: when both requesters are valid, the one not served last wins; a single valid requester always wins.
REQ-022 On acceptance (VALID and READY high at a clock edge), the block SHALL latch the operand, mode and id, drive LZC_MODE from the latched mode, and go to SETUP.
REQ-023 SETUP SHALL last one cycle with LZC_IVALID=0 and LZC_MODE already stable, so that mode precedes the first data word by one cycle.
REQ-024 FEED SHALL last exactly WORD cycles with LZC_IVALID=1, driving LZC_DATA with operand words most-significant first and holding LZC_MODE constant.
REQ-025 After FEED, the block SHALL enter WAIT with LZC_IVALID=0, LZC_DATA=0 and the timeout counter cleared.
REQ-026 In WAIT, the first LZC_OVALID=1 SHALL capture LZC_ZEROS, set ERR=0, and move the FSM to RESP.
REQ-027 If TIMEOUT WAIT cycles elapse without LZC_OVALID, the block SHALL set ZEROS=0 and ERR=1, and move the FSM to RESP.
REQ-028 RESP SHALL last one cycle with RSP_VALID=1, RSP_ID, RSP_ZEROS and RSP_ERR valid; the FSM SHALL then return to IDLE.
REQ-029 RSP_ZEROS and RSP_ERR SHALL hold their values until the next RESP.
REQ-030 Latency SHALL be: acceptance at edge t gives SETUP in cycle t+1, FEED in t+2..t+1+WORD and WAIT from t+2+WORD; OVALID in WAIT cycle w gives RSP_VALID in cycle w+1.
REQ-031 LZC_OVALID in any state other than WAIT SHALL be ignored.
REQ-032 Requester VALID changes after acceptance SHALL NOT affect the in-flight operand.
REQ-033 LZC_ZEROS SHALL pass through unmodified, including the value 32 for an all-zero operand at WIDTH=8, WORD=4.

Reset
REQ-034 While RST is high at a clock edge, the state SHALL go to IDLE and every output SHALL be 0, including READY, LZC_DATA, LZC_MODE and the RSP_* signals.
REQ-035 Reset SHALL clear the word index and the timeout counter, and set the round-robin pointer to "requester 1 served last".
REQ-036 Reset asserted in any state, including mid-FEED or in WAIT, SHALL abort the operation with no RSP_VALID.

Structure
REQ-037 The shared package lzc_pkg SHALL hold the FSM state enumeration, the ZEROS width constant (6) and the requester-id type.
REQ-038 The arbitration logic SHALL be one sub-module, rr_arb2, containing the two-way round-robin grant and the last-served pointer.

Verification (WIDTH=8, WORD=4, TIMEOUT=64)
REQ-039 Single request: REQ0 sends 32'h00000FFF with mode 0, and the model returns ZEROS=20 three cycles after the last word -> LZC_DATA carries 00,00,0F,FF on consecutive cycles one cycle after SETUP, then RSP_VALID=1, ID=0, ZEROS=20, ERR=0.
REQ-040 Contention: both requesters are held valid from reset -> grants alternate 0,1,0,1 and each response carries the correct RSP_ID.
REQ-041 Timeout: the model never asserts OVALID -> RSP_VALID=1, ERR=1, ZEROS=0 exactly 64 cycles after WAIT entry, and the next request is then served normally.
REQ-042 Reset in the 2nd FEED cycle -> on the next cycle all outputs are 0 and the state is IDLE, with no RSP_VALID.
REQ-043 Spurious LZC_OVALID=1 with ZEROS=5 during FEED, then a real OVALID with ZEROS=9 in WAIT -> the response reports ZEROS=9.
REQ-044 All-zero operand with mode 1 -> LZC_MODE=1 from SETUP through FEED, and a model result of 32 is reported as RSP_ZEROS=32.
